// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand magnitudes,
// with the sign fixed up on the final step and a single-cycle bypass for the divide corner cases.
//
// state | meaning
// IDLE  | ready for a request; operands are captured on accept
// CALC  | 32 shift-add (multiply) or restoring-subtract (divide) steps
// DONE  | result held until writeback takes it
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd,
  output logic            out_we
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          out_rd_q, out_rd_d;

  logic                a_signed, b_signed, s1, s2;
  logic                div_zero, div_ovf, accept;
  logic [XLEN-1:0]     mag1, mag2, bypass_res, pick, calc_res;
  logic [XLEN:0]       sum, diff;
  logic [2*XLEN-1:0]   step_acc, prod;

  // Operand decode and the divide corner cases, all evaluated on the live request.
  always_comb begin
    a_signed   = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
    b_signed   = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    s1         = a_signed & rs1_data[XLEN-1];
    s2         = b_signed & rs2_data[XLEN-1];
    mag1       = s1 ? -rs1_data : rs1_data;
    mag2       = s2 ? -rs2_data : rs2_data;
    div_zero   = op[2] && (rs2_data == '0);
    div_ovf    = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    // Overflow: DIV hands back rs1 (the most negative value), REM gives zero.
    bypass_res = div_zero ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : rs1_data);
    accept     = in_valid & in_ready_q;
  end

  // acc holds {hi, lo} of the product, or {remainder, quotient} while dividing.
  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (op_q[2]) begin
      step_acc = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step_acc = {sum, acc_q[XLEN-1:1]};
    end
    prod = neg_q ? -step_acc : step_acc;
    pick = op_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
    if (op_q[2]) begin
      calc_res = neg_q ? -pick : pick;
    end else begin
      calc_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    op_d        = op_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_rd_d    = out_rd_q;
    if (kill) begin
      state_d     = IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d       = op;
            out_rd_d   = rd_addr;
            // Quotient and product take sign s1^s2; remainder follows the dividend.
            neg_d      = (op[2] && op[1]) ? s1 : (s1 ^ s2);
            acc_d      = {{XLEN{1'b0}}, mag1};
            opb_d      = mag2;
            cnt_d      = '0;
            in_ready_d = 1'b0;
            if (div_zero || div_ovf) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              result_d    = bypass_res;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = step_acc;
          if (cnt_q == 5'(XLEN-1)) begin
            state_d     = DONE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            result_d    = calc_res;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_valid_q & out_ready & ~kill & (out_rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        kill;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [4:0]  out_rd;
  logic        out_we;

  int n_assert = 0;
  int n_fail   = 0;
  int we_count = 0;
  int bad_we   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_rd(out_rd),
    .out_we(out_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_we) we_count++;
    if (out_we && out_rd == 5'd0) bad_we++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    int              ia, ib;
    logic            ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input string tag);
    logic [31:0] exp;
    int          exp_lat, cyc, we0;
    logic        byp;
    exp     = ref_model(f, a, b);
    byp     = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = byp ? 1 : 33;
    wait_ready(tag);
    in_valid = 1'b1; op = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    rd_addr = 5'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " result"}, result, exp);
    chk({tag, " out_rd"}, out_rd, rd);
    chk({tag, " in_ready_busy"}, in_ready, 0);
    we0 = we_count;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_result"}, result, exp);
      chk({tag, " hold_in_ready"}, in_ready, 0);
    end
    chk({tag, " no_early_we"}, we_count, we0);
    out_ready = 1'b1;
    if (hold > 0) begin
      in_valid = 1'b1; op = 3'b101; rs1_data = 32'd9; rs2_data = 32'd0; rd_addr = 5'd1;
    end
    #1;
    chk({tag, " out_we"}, out_we, rd != 0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " released"}, out_valid, 0);
    chk({tag, " idle_ready"}, in_ready, 1);
    chk({tag, " we_pulses"}, we_count, we0 + ((rd != 0) ? 1 : 0));
  endtask

  initial begin
    int seen;
    rst = 1'b0; in_valid = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_we", out_we, 0);
    chk("reset result", result, 0);
    chk("reset out_rd", out_rd, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, "mul_7_m3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, "mulhu_max");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, "mulh_m1");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0, "mulhsu_m1");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 0, "rem_m7_2");
    run_op(3'b101, 32'd7, 32'd0, 5'd12, 0, "divu_by0");
    run_op(3'b111, 32'd7, 32'd0, 5'd12, 0, "remu_by0");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "rem_ovf");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "div_ovf");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd14, 0, "divu_max");

    run_op(3'b001, 32'h1234_5678, 32'h8765_4321, 5'd15, 5, "hold_mulh");

    // Kill ten steps into a multiply while a bypass-eligible request is offered.
    wait_ready("kill");
    in_valid = 1'b1; op = 3'b000; rs1_data = 32'd123; rs2_data = 32'd456; rd_addr = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    seen = we_count;
    kill = 1'b1; in_valid = 1'b1; op = 3'b101; rs1_data = 32'd3; rs2_data = 32'd0;
    out_ready = 1'b1;
    @(negedge clk);
    kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("kill out_valid", out_valid, 0);
    chk("kill in_ready", in_ready, 1);
    begin
      int vcnt = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) vcnt++; end
      chk("kill no_result", vcnt, 0);
    end
    chk("kill no_we", we_count, seen);
    run_op(3'b000, 32'd123, 32'd456, 5'd7, 0, "after_kill");

    run_op(3'b000, 32'd7, 32'd9, 5'd0, 0, "mul_rd0");

    // Reset twenty steps into a multiply: the operation must vanish.
    wait_ready("rst_mid");
    in_valid = 1'b1; op = 3'b000; rs1_data = 32'd5; rs2_data = 32'd6; rd_addr = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_mid in_ready", in_ready, 1);
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid out_we", out_we, 0);
    chk("rst_mid result", result, 0);
    chk("rst_mid out_rd", out_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = we_count;
    begin
      int vcnt = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) vcnt++; end
      chk("rst_mid no_result", vcnt, 0);
    end
    out_ready = 1'b0;
    chk("rst_mid no_we", we_count, seen);

    for (int k = 0; k < 30; k++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          sel;
      f   = 3'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      if (sel == 3) a = {{16{a[31]}}, a[15:0]};
      run_op(f, a, b, 5'($urandom), 0, $sformatf("rand%0d_op%0d", k, f));
    end

    chk("x0 never written", bad_we, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports rs1_data, rs2_data  input  32  operands from the register-file read ports.
REQ-008 SHALL have port rd_addr  input  5  destination register.
REQ-009 SHALL have port kill  input  1  synchronous flush of the in-flight operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  writeback accepts the result.
REQ-012 SHALL have port result  output  32  write data for the register-file write port.
REQ-013 SHALL have port out_rd  output  5  write address for the register-file write port.
REQ-014 SHALL have port out_we  output  1  register-file write strobe.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; accept = in_valid & in_ready.
- On accept, operands, op and rd_addr are registered; inputs are don't-care afterwards.
REQ-017 SHALL, on accept of a normal operation, move IDLE->CALC with iteration counter=0.
- Each CALC cycle performs one radix-2 step (shift-add multiply or restoring divide) on magnitudes.
REQ-018 SHALL leave CALC after exactly 32 steps, so out_valid rises in the cycle after accept edge +32.
REQ-019 SHALL compute products as 64-bit results.
- MUL returns low 32 bits; MULH, MULHSU and MULHU return high 32 bits.
- Sign handling: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-020 SHALL give signed results for DIV/REM as follows:
- quotient truncates toward zero;
- remainder takes the sign of rs1;
- DIVU/REMU operate unsigned.
REQ-021 SHALL bypass CALC for divide-by-zero (rs2=0), going IDLE->DONE at the accept edge:
- DIV/DIVU give 0xFFFFFFFF;
- REM/REMU give rs1.
REQ-022 SHALL bypass CALC for signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF), going IDLE->DONE:
- DIV gives 0x80000000;
- REM gives 0.
REQ-023 SHALL, in DONE, hold out_valid=1 with result and out_rd stable until out_ready=1; DONE->IDLE on that edge.
REQ-024 SHALL drive out_we = out_valid & out_ready & (out_rd != 0), so x0 is never written.
REQ-025 SHALL, when kill=1, go to IDLE on the next edge from any state with no out_we and out_valid low.
- kill has priority over accept and over out_ready in the same cycle.
REQ-026 SHALL NOT accept a new request in the cycle DONE->IDLE (in_ready is 0 in DONE); back-to-back issue has a one-cycle bubble.

Reset
REQ-027 SHALL, while rst=0, asynchronously enter IDLE: in_ready=1, out_valid=0, out_we=0, result=0, out_rd=0, counter=0.
REQ-028 SHALL, if reset asserts mid-CALC or in DONE, discard the operation; no result is produced after release.

Verification
REQ-029 SHALL cover: MUL rs1=7, rs2=-3, rd=5 -> after 32 cycles result=0xFFFFFFEB, out_rd=5, out_we=1 with out_ready=1.
REQ-030 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000.
REQ-031 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF in 1 cycle; REM 0x80000000/-1 -> 0.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and result stable; in_ready=0; single out_we pulse on release.
REQ-033 SHALL cover: kill at CALC step 10 with in_valid=1 -> IDLE next edge, request not accepted, no out_valid; a subsequent op completes correctly.
REQ-034 SHALL cover: rd=0 MUL and reset asserted at CALC step 20 -> out_we never 1 for rd=0; post-reset outputs equal REQ-027 values.
